// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: opcodes, tracked register
// numbers and the controller state encoding.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [4:0] REG_T0 = 5'd8;
  localparam logic [4:0] REG_T1 = 5'd9;
  localparam logic [4:0] REG_T2 = 5'd10;
  localparam logic [4:0] REG_T3 = 5'd11;
  localparam logic [4:0] REG_T4 = 5'd12;
  localparam logic [4:0] REG_T5 = 5'd13;
  localparam logic [4:0] REG_S0 = 5'd16;
  localparam logic [4:0] REG_S1 = 5'd17;
  localparam logic [4:0] REG_S2 = 5'd18;
  localparam logic [4:0] REG_S3 = 5'd19;
  localparam logic [4:0] REG_S4 = 5'd20;
  localparam logic [4:0] REG_S5 = 5'd21;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Only t0-t5 and s0-s5 are scoreboarded; everything else never hazards.
  function automatic logic is_tracked(input logic [4:0] r);
    return ((r >= REG_T0) && (r <= REG_T5)) || ((r >= REG_S0) && (r <= REG_S5));
  endfunction

endpackage

// File: rtl/hazard_ctrl_instr_regdecode.sv
// Combinational register-usage decode of one instruction word: which
// registers it reads, which it writes, and whether it is a jump.
module instr_regdecode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  src1,
  output logic        src1_vld,
  output logic [4:0]  src2,
  output logic        src2_vld,
  output logic [4:0]  dest,
  output logic        dest_vld,
  output logic        is_jump
);

  logic [5:0] op_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic       nop_s;

  assign op_s  = instr[31:26];
  assign rs_s  = instr[25:21];
  assign rt_s  = instr[20:16];
  assign rd_s  = instr[15:11];
  assign nop_s = (instr == 32'h0000_0000);

  // Opcode decode into source/destination fields; unknown opcodes act as NOP.
  always_comb begin
    src1     = rs_s;
    src2     = rt_s;
    dest     = 5'd0;
    src1_vld = 1'b0;
    src2_vld = 1'b0;
    dest_vld = 1'b0;
    is_jump  = 1'b0;
    if (nop_s) begin
      is_jump = 1'b0;
    end else begin
      case (op_s)
        OP_RTYPE: begin
          src1_vld = 1'b1;
          src2_vld = 1'b1;
          dest     = rd_s;
          dest_vld = 1'b1;
        end
        OP_LW, OP_ADDI: begin
          src1_vld = 1'b1;
          dest     = rt_s;
          dest_vld = 1'b1;
        end
        OP_SW, OP_BNE: begin
          src1_vld = 1'b1;
          src2_vld = 1'b1;
        end
        OP_J: begin
          is_jump = 1'b1;
        end
        default: begin
          is_jump = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush controller for the forwarding-less 5-stage MIPS core,
// with its own destination scoreboard and saturating debug counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_instr,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             bubble_id,
  output logic             flush_if,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [4:0]            src1_s;
  logic                  src1_vld_s;
  logic [4:0]            src2_s;
  logic                  src2_vld_s;
  logic [4:0]            dest_s;
  logic                  dest_vld_s;
  logic                  is_jump_s;

  logic [PIPE_DEPTH-1:0] sb_vld_r;
  logic [4:0]            sb_dest_r [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] kept_vld_s;
  logic                  hazard_s;
  logic                  stall_s;
  logic                  bubble_s;
  logic                  issue_s;
  logic                  new_vld_s;
  logic                  flush_if_r;
  state_e                state_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [CNT_W-1:0]      flush_cnt_r;

  instr_regdecode u_decode (
    .instr    (if_instr),
    .src1     (src1_s),
    .src1_vld (src1_vld_s),
    .src2     (src2_s),
    .src2_vld (src2_vld_s),
    .dest     (dest_s),
    .dest_vld (dest_vld_s),
    .is_jump  (is_jump_s)
  );

  // RAW check of the IF sources against every in-flight destination.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      hazard_s = hazard_s | (sb_vld_r[i] &
                 ((src1_vld_s & is_tracked(src1_s) & (sb_dest_r[i] == src1_s)) |
                  (src2_vld_s & is_tracked(src2_s) & (sb_dest_r[i] == src2_s))));
    end
  end

  // Priority resolution: redirect, then pending flush, then hazard, then issue.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    issue_s  = 1'b0;
    if (branch_taken) begin
      bubble_s = 1'b1;
    end else if (flush_if_r) begin
      bubble_s = 1'b1;
    end else if (hazard_s) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
    end else begin
      issue_s = 1'b1;
    end
  end

  // A taken branch kills the wrong-path instruction sitting in ID before the shift.
  always_comb begin
    kept_vld_s    = sb_vld_r;
    kept_vld_s[0] = sb_vld_r[0] & ~branch_taken;
    new_vld_s     = issue_s & dest_vld_s & is_tracked(dest_s);
  end

  // Scoreboard shift register: entry 0 tracks ID, the last entry MEM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_vld_r <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sb_dest_r[i] <= 5'd0;
      end
    end else begin
      sb_vld_r     <= {kept_vld_s[PIPE_DEPTH-2:0], new_vld_s};
      sb_dest_r[0] <= dest_s;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        sb_dest_r[i] <= sb_dest_r[i-1];
      end
    end
  end

  // Controller state and the registered flush request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= RUN;
      flush_if_r <= 1'b0;
    end else if (branch_taken) begin
      state_r    <= FLUSH;
      flush_if_r <= 1'b1;
    end else if (flush_if_r) begin
      state_r    <= RUN;
      flush_if_r <= 1'b0;
    end else if (hazard_s) begin
      state_r    <= STALL;
      flush_if_r <= 1'b0;
    end else if (is_jump_s) begin
      state_r    <= FLUSH;
      flush_if_r <= 1'b1;
    end else begin
      state_r    <= RUN;
      flush_if_r <= 1'b0;
    end
  end

  // Saturating debug counters for stall and flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_if_r && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_if  = stall_s;
  assign bubble_id = bubble_s;
  assign flush_if  = flush_if_r;
  assign state     = state_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, reset cases and
// a randomized run against a queue-based model of the pipeline.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] if_instr;
  logic        branch_taken;
  logic        stall_if;
  logic        bubble_id;
  logic        flush_if;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.PIPE_DEPTH(3), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_instr     (if_instr),
    .branch_taken (branch_taken),
    .stall_if     (stall_if),
    .bubble_id    (bubble_id),
    .flush_if     (flush_if),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    bit          bt;
    bit          e_stall;
    bit          e_bubble;
    bit          e_flush;
    int          e_state;
  } vec_t;

  vec_t tbl[$];

  // ---------------- reference model ----------------
  int m_pipe[$];   // in-flight tracked destination per stage, -1 = none
  bit m_flush;
  int m_state;
  int m_stall_cnt;
  int m_flush_cnt;

  function automatic bit trk(int r);
    return (r >= 8 && r <= 13) || (r >= 16 && r <= 21);
  endfunction

  function automatic void mdecode(input logic [31:0] ins, output int s1, output int s2,
                                  output int d, output bit jmp);
    int op;
    op = int'(ins[31:26]);
    s1 = -1; s2 = -1; d = -1; jmp = 1'b0;
    if (ins != 32'd0) begin
      case (op)
        0:        begin s1 = int'(ins[25:21]); s2 = int'(ins[20:16]); d = int'(ins[15:11]); end
        35, 8:    begin s1 = int'(ins[25:21]); d = int'(ins[20:16]); end
        43, 5:    begin s1 = int'(ins[25:21]); s2 = int'(ins[20:16]); end
        2:        jmp = 1'b1;
        default:  jmp = 1'b0;
      endcase
    end
    if (!trk(d)) d = -1;
  endfunction

  function automatic bit mhazard(input logic [31:0] ins);
    int s1, s2, d;
    bit jmp;
    mdecode(ins, s1, s2, d, jmp);
    foreach (m_pipe[k])
      if (m_pipe[k] >= 0 && (m_pipe[k] == s1 || m_pipe[k] == s2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mreset();
    m_pipe = '{-1, -1, -1};
    m_flush = 1'b0; m_state = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endfunction

  function automatic void mcomb(input logic [31:0] ins, input bit bt,
                                output bit st, output bit bb);
    st = 1'b0; bb = 1'b0;
    if (bt || m_flush) bb = 1'b1;
    else if (mhazard(ins)) begin st = 1'b1; bb = 1'b1; end
  endfunction

  function automatic void madvance(input logic [31:0] ins, input bit bt);
    int s1, s2, d;
    bit jmp;
    mdecode(ins, s1, s2, d, jmp);
    if (m_flush && m_flush_cnt < 65535) m_flush_cnt++;
    if (bt) begin
      m_pipe[0] = -1;
      m_pipe.push_front(-1); void'(m_pipe.pop_back());
      m_flush = 1'b1; m_state = 2;
    end else if (m_flush) begin
      m_pipe.push_front(-1); void'(m_pipe.pop_back());
      m_flush = 1'b0; m_state = 0;
    end else if (mhazard(ins)) begin
      m_pipe.push_front(-1); void'(m_pipe.pop_back());
      if (m_stall_cnt < 65535) m_stall_cnt++;
      m_state = 1;
    end else begin
      m_pipe.push_front(d); void'(m_pipe.pop_back());
      m_flush = jmp; m_state = jmp ? 2 : 0;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rt_i(int rs, int rt, int rd, int fn);
    logic [4:0] a, b, c;
    logic [5:0] f;
    a = rs[4:0]; b = rt[4:0]; c = rd[4:0]; f = fn[5:0];
    return {6'b000000, a, b, c, 5'b00000, f};
  endfunction

  function automatic logic [31:0] it_i(int op, int rs, int rt, int imm);
    logic [5:0] o;
    logic [4:0] a, b;
    logic [15:0] m;
    o = op[5:0]; a = rs[4:0]; b = rt[4:0]; m = imm[15:0];
    return {o, a, b, m};
  endfunction

  function automatic void addv(logic [31:0] ins, bit bt, bit s, bit b, bit f, int st);
    vec_t v;
    v.ins = ins; v.bt = bt; v.e_stall = s; v.e_bubble = b; v.e_flush = f; v.e_state = st;
    tbl.push_back(v);
  endfunction

  task automatic drive(input logic [31:0] ins, input bit bt);
    @(negedge clk);
    if_instr = ins;
    branch_taken = bt;
    #1;
  endtask

  // Full model comparison for one cycle, then advance the model.
  task automatic step_model(input logic [31:0] ins, input bit bt);
    bit es, eb;
    drive(ins, bt);
    mcomb(ins, bt, es, eb);
    chk("stall_if", int'(stall_if), int'(es));
    chk("bubble_id", int'(bubble_id), int'(eb));
    chk("flush_if", int'(flush_if), int'(m_flush));
    chk("state", int'(state), m_state);
    chk("stall_cnt", int'(stall_cnt), m_stall_cnt);
    chk("flush_cnt", int'(flush_cnt), m_flush_cnt);
    madvance(ins, bt);
  endtask

  function automatic int rand_reg();
    int pool[15] = '{0, 2, 8, 9, 10, 11, 12, 13, 16, 17, 18, 19, 20, 21, 31};
    return pool[$urandom_range(0, 14)];
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return rt_i(rand_reg(), rand_reg(), rand_reg(), 32);
      2:       return it_i(35, rand_reg(), rand_reg(), 4);
      3:       return it_i(8, rand_reg(), rand_reg(), 1);
      4:       return it_i(43, rand_reg(), rand_reg(), 8);
      5:       return it_i(5, rand_reg(), rand_reg(), 3);
      6:       return (($urandom_range(0, 3) == 0) ? {6'b000010, 26'd64} : rt_i(rand_reg(), rand_reg(), rand_reg(), 34));
      default: return it_i(13, rand_reg(), rand_reg(), 7);
    endcase
  endfunction

  localparam int T0 = 8, T1 = 9, T2 = 10, T3 = 11, T4 = 12, T5 = 13;
  localparam int S0 = 16, S1 = 17, S2 = 18, S3 = 19;

  initial begin
    logic [31:0] nop, jmp_i;
    nop = 32'd0;
    jmp_i = {6'b000010, 26'd100};
    rst = 1'b0;
    if_instr = 32'd0;
    branch_taken = 1'b0;
    mreset();

    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_flush_if", int'(flush_if), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    chk("rst_stall_if", int'(stall_if), 0);
    chk("rst_bubble_id", int'(bubble_id), 0);
    @(negedge clk);
    rst = 1'b1;

    // dependent R-type: 3 stalls
    addv(rt_i(S0, S1, T0, 32), 0, 0, 0, 0, 0);
    addv(rt_i(T0, S2, T1, 34), 0, 1, 1, 0, 0);
    addv(rt_i(T0, S2, T1, 34), 0, 1, 1, 0, 1);
    addv(rt_i(T0, S2, T1, 34), 0, 1, 1, 0, 1);
    addv(rt_i(T0, S2, T1, 34), 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) addv(nop, 0, 0, 0, 0, 0);
    // load-use with one independent instruction between: 2 stalls
    addv(it_i(35, T2, S1, 0), 0, 0, 0, 0, 0);
    addv(it_i(8, T4, T3, 1), 0, 0, 0, 0, 0);
    addv(rt_i(S1, S1, T5, 32), 0, 1, 1, 0, 0);
    addv(rt_i(S1, S1, T5, 32), 0, 1, 1, 0, 1);
    addv(rt_i(S1, S1, T5, 32), 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) addv(nop, 0, 0, 0, 0, 0);
    // untracked registers never stall
    addv(rt_i(3, 4, 2, 32), 0, 0, 0, 0, 0);
    addv(rt_i(2, 2, 5, 32), 0, 0, 0, 0, 0);
    addv(nop, 0, 0, 0, 0, 0);
    // jump: following addi is flushed and never scoreboarded
    addv(jmp_i, 0, 0, 0, 0, 0);
    addv(it_i(8, T0, T0, 1), 0, 0, 1, 1, 2);
    addv(rt_i(T0, T0, T1, 32), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(nop, 0, 0, 0, 0, 0);
    // taken bne on the 2nd stall cycle cancels the stall
    addv(rt_i(S0, S1, S3, 32), 0, 0, 0, 0, 0);
    addv(rt_i(S3, S3, T2, 32), 0, 1, 1, 0, 0);
    addv(rt_i(S3, S3, T2, 32), 1, 0, 1, 0, 1);
    addv(it_i(8, T0, T0, 1), 0, 0, 1, 1, 2);
    addv(nop, 0, 0, 0, 0, 0);
    addv(nop, 0, 0, 0, 0, 0);
    // taken branch invalidates the real producer sitting in ID
    addv(rt_i(S0, S0, T3, 32), 0, 0, 0, 0, 0);
    addv(nop, 1, 0, 1, 0, 0);
    addv(nop, 0, 0, 1, 1, 2);
    addv(rt_i(T3, T3, T4, 32), 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addv(nop, 0, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      drive(tbl[k].ins, tbl[k].bt);
      chk($sformatf("v%0d_stall_if", k), int'(stall_if), int'(tbl[k].e_stall));
      chk($sformatf("v%0d_bubble_id", k), int'(bubble_id), int'(tbl[k].e_bubble));
      chk($sformatf("v%0d_flush_if", k), int'(flush_if), int'(tbl[k].e_flush));
      chk($sformatf("v%0d_state", k), int'(state), tbl[k].e_state);
      madvance(tbl[k].ins, tbl[k].bt);
    end
    drive(nop, 0);
    chk("tbl_stall_cnt", int'(stall_cnt), 6);
    chk("tbl_flush_cnt", int'(flush_cnt), 3);
    madvance(nop, 0);

    // reset asserted mid-stall
    step_model(rt_i(S0, S1, T0, 32), 0);
    step_model(rt_i(T0, T0, T1, 32), 0);
    step_model(rt_i(T0, T0, T1, 32), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    if_instr = 32'd0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_flush_if", int'(flush_if), 0);
    chk("midrst_stall_cnt", int'(stall_cnt), 0);
    chk("midrst_flush_cnt", int'(flush_cnt), 0);
    chk("midrst_stall_if", int'(stall_if), 0);
    chk("midrst_bubble_id", int'(bubble_id), 0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    step_model(rt_i(T0, T0, T1, 32), 0);
    chk("postrst_no_stall", int'(stall_if), 0);

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      step_model(rand_instr(), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
